// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: D = a - b - Bin, Bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = a ^ b ^ Bin;
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, Q = {borrow_out, a - b - Bin} after WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH:0]   Q,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [WIDTH:0]   q_r;
  logic             busy_r;
  logic             done_r;
  logic             d_s;
  logic             bout_s;
  logic             last_s;

  full_subtractor u_fs (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .Bin  (br_r),
    .D    (d_s),
    .Bout (bout_s)
  );

  // Terminal count: the RUN edge that consumes bit WIDTH-1.
  assign last_s = (state_r == S_RUN) && (cnt_r == LAST_CNT);

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = S_RUN;
        else       state_next_s = S_IDLE;
      end
      S_RUN: begin
        if (last_s) state_next_s = S_DONE;
        else        state_next_s = S_RUN;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Datapath: operand capture, serial shift, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      a_sr_r <= '0;
      b_sr_r <= '0;
      res_r  <= '0;
      br_r   <= 1'b0;
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_next_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            a_sr_r <= a;
            b_sr_r <= b;
            br_r   <= Bin;
            cnt_r  <= '0;
          end
        end
        S_RUN: begin
          a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_r  <= {d_s, res_r[WIDTH-1:1]};
          br_r   <= bout_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (last_s) begin
            q_r    <= {bout_s, d_s, res_r[WIDTH-1:1]};
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_r <= 1'b0;
    else if (last_s) ovf_r <= br_r ^ bout_s;
    else             ovf_r <= ovf_r;
  end

  assign ovf = ovf_r;
`endif

  assign Q    = q_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): expectations are queued at
// issue, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       bin = 1'b0;
  logic [4:0] q;
  logic       busy;
  logic       done;
  logic       ovf_v;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic [5:0] exp_q[$];
  int done_cyc[$];

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .Bin   (bin),
    .Q     (q),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf_v)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_v = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("Q", {27'd0, q}, {27'd0, e[4:0]});
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {31'd0, ovf_v}, {31'd0, e[5]});
`endif
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation, scramble inputs after acceptance, measure busy length.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [4:0] eq, input logic eovf);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    exp_q.push_back({eovf, eq});
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        a = ~ta; b = ~tb_v; bin = ~tbin;
      end
      if (busy) n++;
      else break;
    end
    check("busy_len", n, 32'd5);
  endtask

  initial begin
    #2;
    check("rst_Q", {27'd0, q}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf", {31'd0, ovf_v}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd9, 4'd3, 1'b0, 5'b00110, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 5'b11111, 1'b0);
    run_op(4'd15, 4'd15, 1'b0, 5'b00000, 1'b0);
    run_op(4'd3, 4'd9, 1'b0, 5'b11010, 1'b0);

    // Abort mid-run: Q held 11010 before reset, must clear immediately.
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_Q", {27'd0, q}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd5, 4'd2, 1'b0, 5'b00011, 1'b0);

    // Held start: two back-to-back operations, a perturbed during first RUN.
    done_cyc.delete();
    @(negedge clk);
    a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 5'b00101});
    exp_q.push_back({1'b0, 5'b00101});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) a = 4'hF;
      if (i == 2) a = 4'd6;
    end
    start = 1'b0;
    wait_idle();
    check("held_done_count", done_cyc.size(), 32'd2);
    if (done_cyc.size() == 2)
      check("held_done_spacing", done_cyc[1] - done_cyc[0], 32'd6);

    run_op(4'd8, 4'd1, 1'b0, 5'b00111, 1'b1);
    run_op(4'd7, 4'd15, 1'b0, 5'b11000, 1'b1);
    run_op(4'd5, 4'd2, 1'b0, 5'b00011, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
